// File: rtl/mem_arb.sv
// Two-requester (fetch / load-store) arbiter in front of a single-outstanding memory port.
// Round-robin grant in IDLE, then waits for the one response and routes it back.
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,

    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IFU = 2'd1,
        WAIT_LSU = 2'd2
    } state_t;

    state_t state;
    logic   prio_lsu;
    logic   idle_active;
    logic   grant_lsu;
    logic   handshake;

    // Qualified by rst so every handshake/valid output is quiet while reset is held.
    assign idle_active = rst && (state == IDLE);
    assign grant_lsu   = lsu_req_valid && (!ifu_req_valid || prio_lsu);

    assign mem_req_valid = idle_active && (ifu_req_valid || lsu_req_valid);
    assign handshake     = mem_req_valid && mem_req_ready;

    assign ifu_req_ready = mem_req_valid && !grant_lsu && mem_req_ready;
    assign lsu_req_ready = mem_req_valid &&  grant_lsu && mem_req_ready;

    assign ifu_resp_valid = rst && (state == WAIT_IFU) && mem_resp_valid;
    assign lsu_resp_valid = rst && (state == WAIT_LSU) && mem_resp_valid;
    assign ifu_rdata      = mem_rdata;
    assign lsu_rdata      = mem_rdata;

    assign busy = (state != IDLE);

    // Payload is zero whenever no request is being presented, including while waiting.
    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (mem_req_valid) begin
            if (grant_lsu) begin
                mem_addr  = lsu_addr;
                mem_wen   = lsu_wen;
                mem_wdata = lsu_wdata;
                mem_wmask = lsu_wmask;
            end else begin
                mem_addr  = ifu_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prio_lsu <= 1'b1;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A response with nothing outstanding is a protocol violation.
                    if (mem_resp_valid) begin
                        err <= 1'b1;
                    end
                    if (handshake) begin
                        state    <= grant_lsu ? WAIT_LSU : WAIT_IFU;
                        prio_lsu <= !grant_lsu;
                    end
                end
                WAIT_IFU, WAIT_LSU: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomized run, all checked
// against a transaction-level model of who owns the memory port.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req_valid, mem_wen, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        busy, err;

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner of the memory port (0 none, 1 fetch, 2 load/store), fairness bit, error flag.
    int m_owner;
    bit m_prio;
    bit m_err;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    function automatic logic [139:0] got_vec();
        return {mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                busy, err, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata};
    endfunction

    function automatic logic [139:0] model_out();
        bit          live = (rst === 1'b1);
        bit          lwin = lsu_req_valid && (!ifu_req_valid || m_prio);
        bit          mrv  = live && (m_owner == 0) && (ifu_req_valid || lsu_req_valid);
        logic [31:0] a  = '0;
        logic [31:0] wd = '0;
        logic        w  = 1'b0;
        logic [3:0]  wm = '0;
        if (mrv) begin
            if (lwin) begin
                a = lsu_addr; w = lsu_wen; wd = lsu_wdata; wm = lsu_wmask;
            end else begin
                a = ifu_addr;
            end
        end
        return {mrv, mrv && !lwin && mem_req_ready, mrv && lwin && mem_req_ready,
                live && (m_owner == 1) && mem_resp_valid, live && (m_owner == 2) && mem_resp_valid,
                m_owner != 0, m_err, a, w, wd, wm, mem_rdata, mem_rdata};
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_prio  = 1'b1;
        m_err   = 1'b0;
    endtask

    task automatic model_update();
        bit lwin = lsu_req_valid && (!ifu_req_valid || m_prio);
        bit mrv  = (ifu_req_valid || lsu_req_valid);
        if (rst !== 1'b1) return;
        if (m_owner == 0) begin
            if (mem_resp_valid) m_err = 1'b1;
            if (mrv && mem_req_ready) begin
                m_owner = lwin ? 2 : 1;
                m_prio  = !lwin;
            end
        end else if (mem_resp_valid) begin
            m_owner = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
        ifu_addr = 32'h1000; lsu_addr = 32'h2000; mem_rdata = 32'h5A5A5A5A;
        #1;
        n_cmp++;
        if (got_vec() !== model_out()) begin
            n_err++; $display("FAIL reset_outputs got=%h exp=%h", got_vec(), model_out());
        end
        n_cmp++;
        if ({busy, err, mem_req_valid, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 7'b0) begin
            n_err++; $display("FAIL reset_quiet got=%b exp=0", {busy, err, mem_req_valid, ifu_req_ready, lsu_req_ready});
        end
        @(negedge clk);
        mem_resp_valid = 0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({lsu_req_ready, ifu_req_ready, mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
            n_err++; $display("FAIL first_arb got=%b%b/%h exp=10/00002000", lsu_req_ready, ifu_req_ready, mem_addr);
        end
        tick();
    endtask

    task automatic test_single_fetch();
        int busy_cnt = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ifu_req_valid  = (c == 0);
            ifu_addr       = 32'h80000000;
            mem_req_ready  = 1;
            mem_resp_valid = (c == 2);
            mem_rdata      = (c == 2) ? 32'h00000413 : 32'h0;
            #1;
            n_cmp++;
            if (got_vec() !== model_out()) begin
                n_err++; $display("FAIL fetch_c%0d got=%h exp=%h", c, got_vec(), model_out());
            end
            if (busy) busy_cnt++;
            if (c == 2) begin
                n_cmp++;
                if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {1'b1, 1'b0, 32'h00000413}) begin
                    n_err++; $display("FAIL fetch_resp got=%b%b/%h exp=10/00000413", ifu_resp_valid, lsu_resp_valid, ifu_rdata);
                end
            end
            tick();
        end
        n_cmp++;
        if (busy_cnt != 2) begin
            n_err++; $display("FAIL fetch_busy_cycles got=%0d exp=2", busy_cnt);
        end
    endtask

    task automatic test_contention();
        int who;
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h80000004;
        lsu_req_valid = 1; lsu_addr = 32'h80001000; lsu_wen = 0;
        mem_req_ready = 1;
        for (int t = 0; t < 6; t++) begin
            mem_resp_valid = 0;
            #1;
            n_cmp++;
            if (got_vec() !== model_out()) begin
                n_err++; $display("FAIL contend_req%0d got=%h exp=%h", t, got_vec(), model_out());
            end
            who = lsu_req_ready ? 2 : (ifu_req_ready ? 1 : 0);
            n_cmp++;
            if (who != ((t % 2 == 0) ? 2 : 1)) begin
                n_err++; $display("FAIL contend_grant%0d got=%0d exp=%0d", t, who, (t % 2 == 0) ? 2 : 1);
            end
            tick();
            mem_resp_valid = 1;
            mem_rdata = $urandom;
            #1;
            n_cmp++;
            if (got_vec() !== model_out()) begin
                n_err++; $display("FAIL contend_resp%0d got=%h exp=%h", t, got_vec(), model_out());
            end
            tick();
        end
    endtask

    task automatic test_store();
        do_reset();
        ifu_req_valid = 1; ifu_addr = 32'h80000010;
        lsu_req_valid = 1; lsu_addr = 32'h80002000; lsu_wen = 1;
        lsu_wdata = 32'hDEADBEEF; lsu_wmask = 4'hF; mem_req_ready = 1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) lsu_req_valid = 0;
            mem_resp_valid = (c == 2);
            #1;
            n_cmp++;
            if (got_vec() !== model_out()) begin
                n_err++; $display("FAIL store_c%0d got=%h exp=%h", c, got_vec(), model_out());
            end
            n_cmp++;
            if (ifu_req_ready !== 1'b0) begin
                n_err++; $display("FAIL store_ifu_ready_c%0d got=%b exp=0", c, ifu_req_ready);
            end
            if (c == 0) begin
                n_cmp++;
                if ({mem_req_valid, mem_wen, mem_wdata, mem_wmask, mem_addr, lsu_req_ready} !==
                    {1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 32'h80002000, 1'b1}) begin
                    n_err++; $display("FAIL store_payload got=%b%b/%h/%h/%h exp=11/deadbeef/f/80002000",
                                      mem_req_valid, mem_wen, mem_wdata, mem_wmask, mem_addr);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if (lsu_resp_valid !== 1'b1) begin
                    n_err++; $display("FAIL store_ack got=%b exp=1", lsu_resp_valid);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        logic [31:0] a = $urandom;
        do_reset();
        ifu_req_valid = 1; ifu_addr = a;
        for (int c = 0; c < 6; c++) begin
            mem_req_ready = (c == 5);
            #1;
            n_cmp++;
            if (got_vec() !== model_out()) begin
                n_err++; $display("FAIL bp_c%0d got=%h exp=%h", c, got_vec(), model_out());
            end
            n_cmp++;
            if ({ifu_req_ready, busy, mem_addr} !== {(c == 5), 1'b0, a}) begin
                n_err++; $display("FAIL bp_state_c%0d got=%b%b/%h exp=%b0/%h", c, ifu_req_ready, busy, mem_addr, (c == 5), a);
            end
            tick();
        end
        ifu_req_valid = 0; mem_req_ready = 0;
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL bp_accepted got=%b exp=1", busy);
        end
        tick();
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
    endtask

    task automatic test_spurious();
        do_reset();
        mem_resp_valid = 1; mem_rdata = $urandom;
        #1;
        n_cmp++;
        if (got_vec() !== model_out()) begin
            n_err++; $display("FAIL spur_c0 got=%h exp=%h", got_vec(), model_out());
        end
        tick();
        mem_resp_valid = 0;
        for (int c = 0; c < 3; c++) begin
            ifu_req_valid = (c == 1); mem_req_ready = 1; mem_resp_valid = (c == 2);
            #1;
            n_cmp++;
            if ({err, got_vec()} !== {1'b1, model_out()}) begin
                n_err++; $display("FAIL spur_sticky_c%0d got=%h exp=%h", c, got_vec(), model_out());
            end
            tick();
        end
        idle_inputs();
        do_reset();
        #1;
        n_cmp++;
        if (err !== 1'b0) begin
            n_err++; $display("FAIL spur_cleared got=%b exp=0", err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        lsu_req_valid = 1; lsu_addr = 32'h80003000; mem_req_ready = 1;
        #1;
        tick();
        lsu_req_valid = 0;
        #1;
        n_cmp++;
        if (got_vec() !== model_out()) begin
            n_err++; $display("FAIL rwait_busy got=%h exp=%h", got_vec(), model_out());
        end
        @(negedge clk);
        mem_resp_valid = 1;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({lsu_resp_valid, busy} !== 2'b00) begin
            n_err++; $display("FAIL rwait_abandon got=%b%b exp=00", lsu_resp_valid, busy);
        end
        tick();
        rst = 1'b1;
        ifu_req_valid = 1; ifu_addr = 32'h80000020;
        lsu_req_valid = 1; lsu_addr = 32'h80003004; mem_req_ready = 0;
        #1;
        n_cmp++;
        if ({got_vec(), mem_addr} !== {model_out(), 32'h80003004}) begin
            n_err++; $display("FAIL rwait_prio got=%h exp=%h", got_vec(), model_out());
        end
        tick();
        mem_resp_valid = 0;
        #1;
        n_cmp++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL rwait_late_err got=%b exp=1", err);
        end
        idle_inputs();
    endtask

    task automatic test_random(input int cycles);
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            if (rst === 1'b0) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                model_reset();
            end
            ifu_req_valid  = ($urandom_range(0, 9) < 6);
            lsu_req_valid  = ($urandom_range(0, 9) < 6);
            ifu_addr       = $urandom;
            lsu_addr       = $urandom;
            lsu_wen        = $urandom_range(0, 1);
            lsu_wdata      = $urandom;
            lsu_wmask      = 4'($urandom_range(0, 15));
            mem_req_ready  = ($urandom_range(0, 9) < 7);
            mem_resp_valid = ($urandom_range(0, 9) < 3);
            mem_rdata      = $urandom;
            #1;
            n_cmp++;
            if (got_vec() !== model_out()) begin
                n_err++; $display("FAIL rand_c%0d got=%h exp=%h", i, got_vec(), model_out());
            end
            tick();
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_backpressure();
        test_spurious();
        test_reset_in_wait();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
